// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM decimator: third-order CIC (three integrators at the microphone
// rate, decimate by DECIM, three differential-delay-1 combs at the output
// rate) followed by a one-deep AXI-Stream output register with an overrun
// flag. All CIC arithmetic wraps modulo 2^ACC_W by design.
module pdm_cic_decimator #(
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_rising,
  input  logic             mic_data,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             overrun
);

  // Bit growth of an order-3 CIC is 3*log2(DECIM); two extra bits cover the
  // +/-1 input sample and its sign.
  localparam int ACC_W = 3 * $clog2(DECIM) + 2;
  localparam int CNT_W = $clog2(DECIM);
  localparam int N_STG = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECIM - 1);

  // ---------------------------------------------------------------------------
  // Input mapping: 1 -> +1, 0 -> -1, sign-extended to the accumulator width
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] w_sample;
  assign w_sample = mic_data ? ACC_W'(1) : {ACC_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Integrator cascade. Each stage adds the previous stage's registered value,
  // so the chain is pipelined by one microphone pulse per stage; this only
  // delays the response and leaves the filter gain unchanged.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] w_int_in  [N_STG];
  logic [ACC_W-1:0] w_int_out [N_STG];

  assign w_int_in[0] = w_sample;

  genvar gi;
  generate
    for (gi = 1; gi < N_STG; gi++) begin : g_int_link
      assign w_int_in[gi] = w_int_out[gi-1];
    end

    for (gi = 0; gi < N_STG; gi++) begin : g_int
      logic [ACC_W-1:0] r_acc;

      // Accumulate on microphone rising edges only; wraps modulo 2^ACC_W
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_acc <= '0;
        end else if (clk_rising) begin
          r_acc <= r_acc + w_int_in[gi];
        end
      end

      assign w_int_out[gi] = r_acc;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Decimation counter and strobe pipeline
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;
  logic [N_STG:0]   r_strobe;

  assign w_wrap = clk_rising && (r_cnt == CNT_MAX);

  // Count microphone pulses 0..DECIM-1; the pulse at DECIM-1 completes a sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clk_rising) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Shift the decimation strobe one stage per clk: bit k enables comb stage k,
  // the top bit loads the output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe <= '0;
    end else begin
      r_strobe <= {r_strobe[N_STG-1:0], w_wrap};
    end
  end

  // ---------------------------------------------------------------------------
  // Comb cascade: y = x - x_prev, one registered stage per clk cycle. The
  // delay register advances only when its own stage fires, i.e. once per
  // output sample.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] w_comb_in  [N_STG];
  logic [ACC_W-1:0] w_comb_out [N_STG];

  assign w_comb_in[0] = w_int_out[N_STG-1];

  generate
    for (gi = 1; gi < N_STG; gi++) begin : g_comb_link
      assign w_comb_in[gi] = w_comb_out[gi-1];
    end

    for (gi = 0; gi < N_STG; gi++) begin : g_comb
      logic [ACC_W-1:0] r_diff;
      logic [ACC_W-1:0] r_dly;

      // Differentiate against the value captured at the previous decimated sample
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_diff <= '0;
          r_dly  <= '0;
        end else if (r_strobe[gi]) begin
          r_diff <= w_comb_in[gi] - r_dly;
          r_dly  <= w_comb_in[gi];
        end
      end

      assign w_comb_out[gi] = r_diff;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  logic             w_load;
  logic             w_xfer;
  logic [OUT_W-1:0] w_pcm;
  logic [OUT_W-1:0] r_tdata;
  logic             r_tvalid;
  logic             r_overrun;

  assign w_load = r_strobe[N_STG];
  assign w_xfer = r_tvalid && m_axis_tready;
  // Keep the top OUT_W bits: arithmetic shift right by ACC_W-OUT_W, truncated
  assign w_pcm  = w_comb_out[N_STG-1][ACC_W-1 -: OUT_W];

  // A new sample always wins; overwriting an unconsumed sample is flagged stickily
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_tdata  <= w_pcm;
        r_tvalid <= 1'b1;
        if (r_tvalid && !m_axis_tready) begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench for pdm_cic_decimator: the stimulus pushes one expected
// sample per completed 64-pulse group; a forked monitor pops on every
// handshake and checks data and latency.
module tb_pdm_cic_decimator;

  localparam int DECIM = 64;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_rising;
  logic             mic_data;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             overrun;

  pdm_cic_decimator #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_rising    (clk_rising),
    .mic_data      (mic_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          chk;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   hs_count = 0;
  int   pcount   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  // Pop one expectation per handshake; compare data (steady-state samples) and latency
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && m_axis_tvalid && m_axis_tready) begin
        hs_count++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_sample: got tdata 0x%0h, expected no sample", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          if (e.chk) check("tdata", 32'(m_axis_tdata), 32'(e.val));
          check("latency", 32'(cyc - e.cyc), 32'd4);
        end
      end
    end
  endtask

  // Asynchronous reset asserted between clock edges, released on a falling edge
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    pcount = 0;
    sb.delete();
  endtask

  // One microphone pulse; every 64th pulse completes a sample and queues its expectation
  task automatic pulse(input bit d, input int gap, input bit chk_en, input logic [15:0] expv);
    exp_t e;
    clk_rising = 1'b1;
    mic_data   = d;
    @(negedge clk);
    clk_rising = 1'b0;
    pcount++;
    if (pcount % DECIM == 0) begin
      e.chk = chk_en && (pcount / DECIM >= 4);
      e.val = expv;
      e.cyc = cyc;
      sb.push_back(e);
    end
    repeat (gap - 1) @(negedge clk);
  endtask

  // pat: 0 = all ones, 1 = all zeros, 2 = alternating starting with 1
  task automatic run_groups(input int pat, input int ngroups, input int gap,
                            input bit chk_en, input logic [15:0] expv);
    bit d;
    for (int i = 0; i < ngroups * DECIM; i++) begin
      d = (pat == 0) ? 1'b1 : (pat == 1) ? 1'b0 : (i % 2 == 0);
      pulse(d, gap, chk_en, expv);
    end
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    check("queue_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    clk_rising    = 1'b0;
    mic_data      = 1'b0;
    m_axis_tready = 1'b0;
    fork
      monitor();
    join_none

    // Outputs stay cleared while reset is held, whatever the inputs do
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clk_rising    = ~clk_rising;
      mic_data      = ~mic_data;
      m_axis_tready = ~m_axis_tready;
    end
    check("reset_hold_outputs", {13'd0, m_axis_tvalid, overrun, 1'b0, m_axis_tdata}, 32'd0);
    clk_rising    = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_release_outputs", {13'd0, m_axis_tvalid, overrun, 1'b0, m_axis_tdata}, 32'd0);

    // Constant ones, zeros, alternating at 42-clk pulse spacing
    mon_en = 1'b1;
    run_groups(0, 5, 42, 1'b1, 16'h4000);
    drain();
    do_reset();
    run_groups(1, 5, 42, 1'b1, 16'hC000);
    drain();
    do_reset();
    run_groups(2, 5, 42, 1'b1, 16'h0000);
    drain();

    // Exactly 640 pulses -> exactly 10 handshakes
    do_reset();
    hs_count = 0;
    run_groups(0, 10, 6, 1'b1, 16'h4000);
    drain();
    check("handshakes_640", 32'(hs_count), 32'd10);
    check("overrun_clear", 32'(overrun), 32'd0);

    // Two completions with tready low -> overwrite and sticky overrun
    do_reset();
    run_groups(0, 4, 6, 1'b1, 16'h4000);
    drain();
    mon_en        = 1'b0;
    m_axis_tready = 1'b0;
    run_groups(0, 1, 6, 1'b0, 16'h0000);
    repeat (6) @(negedge clk);
    check("stall1_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("stall1_overrun", 32'(overrun), 32'd0);
    run_groups(0, 1, 6, 1'b0, 16'h0000);
    repeat (6) @(negedge clk);
    check("stall2_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("stall2_tdata", 32'(m_axis_tdata), 32'h4000);
    check("stall2_overrun", 32'(overrun), 32'd1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("drain_overrun_sticky", 32'(overrun), 32'd1);

    // Pending sample plus overrun, then reset 30 pulses into the next group
    m_axis_tready = 1'b0;
    run_groups(0, 1, 6, 1'b0, 16'h0000);
    repeat (6) @(negedge clk);
    check("pre_reset_tvalid", 32'(m_axis_tvalid), 32'd1);
    for (int i = 0; i < 30; i++) pulse(1'b1, 6, 1'b0, 16'h0000);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {13'd0, m_axis_tvalid, overrun, 1'b0, m_axis_tdata}, 32'd0);
    repeat (3) @(negedge clk);
    reset         = 1'b0;
    pcount        = 0;
    sb.delete();
    m_axis_tready = 1'b1;
    hs_count      = 0;
    mon_en        = 1'b1;
    for (int i = 0; i < 63; i++) pulse(1'b1, 6, 1'b0, 16'h0000);
    repeat (8) @(negedge clk);
    check("no_sample_before_64", 32'(hs_count), 32'd0);
    pulse(1'b1, 6, 1'b0, 16'h0000);
    drain();
    check("sample_after_64", 32'(hs_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
